// File: rtl/move_list_sequencer.sv
// move_list_sequencer: loads one move list into the sort RAM, runs the sort, then streams the sorted entries out
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif
module move_list_sequencer #(
  parameter int RAM_WIDTH = 0,
  parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS),
  parameter int RD_LATENCY = 1,
  localparam int DW = (RAM_WIDTH > 0) ? RAM_WIDTH : 1,
  localparam int MW = MAX_POSITIONS_LOG2,
  localparam int LW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          list_start,
  input  logic          list_white_to_move,
  input  logic          gen_valid,
  input  logic [DW-1:0] gen_data,
  output logic          gen_ready,
  input  logic          gen_done,
  output logic          busy,
  output logic          overflow,
  output logic [MW-1:0] move_count,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [MW-1:0] out_index,
  output logic          out_last,
  input  logic          out_ready,
  output logic          list_done,
  output logic          sort_start,
  output logic          sort_clear,
  output logic          white_to_move,
  output logic          ram_wr_addr_init,
  output logic          ram_wr,
  output logic [DW-1:0] ram_wr_data,
  output logic [MW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  input  logic [MW-1:0] ram_wr_addr,
  input  logic          sort_complete
);
  typedef enum logic [2:0] {IDLE, INIT, LOAD, START, SORT_WAIT, SETTLE, DRAIN, FINISH} state_t;
  localparam logic [LW-1:0] LAT = LW'(RD_LATENCY);
  state_t state_q, state_d;
  logic busy_q, busy_d, overflow_q, overflow_d, white_q, white_d, settle_q, settle_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [MW-1:0] move_count_q, move_count_d, rd_addr_q, rd_addr_d, out_index_q, out_index_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [LW-1:0] lat_q, lat_d;
  logic full, accept, capture, last_addr;
  assign full = ram_wr_addr == {MW{1'b1}};
  assign last_addr = rd_addr_q == move_count_q - MW'(1);
  assign ram_wr_data = gen_data;
  assign busy = busy_q;
  assign overflow = overflow_q;
  assign white_to_move = white_q;
  assign move_count = move_count_q;
  assign ram_rd_addr = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_index = out_index_q;
  assign out_last = out_last_q;
  // Next state, sorter strobes and the drain output register; an entry is captured once its read
  // latency has elapsed and the output slot is free, prefetching the next address at the same time.
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    overflow_d = overflow_q;
    white_d = white_q;
    settle_d = settle_q;
    move_count_d = move_count_q;
    rd_addr_d = rd_addr_q;
    lat_d = lat_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    out_index_d = out_index_q;
    out_data_d = out_data_q;
    gen_ready = 1'b0;
    ram_wr = 1'b0;
    ram_wr_addr_init = 1'b0;
    sort_start = 1'b0;
    sort_clear = 1'b0;
    list_done = 1'b0;
    accept = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (list_start) begin
        state_d = INIT;
        busy_d = 1'b1;
        overflow_d = 1'b0;
        white_d = list_white_to_move;
      end
      INIT: begin
        ram_wr_addr_init = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        gen_ready = 1'b1;
        ram_wr = gen_valid && !full;
        overflow_d = overflow_q || (gen_valid && full);
        state_d = gen_done ? START : LOAD;
      end
      START: begin
        sort_start = 1'b1;
        move_count_d = ram_wr_addr;
        state_d = SORT_WAIT;
      end
      SORT_WAIT: if (sort_complete) begin
        sort_clear = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        rd_addr_d = '0;
        lat_d = '0;
        settle_d = !settle_q;
        if (settle_q) state_d = (move_count_q == '0) ? FINISH : DRAIN;
      end
      DRAIN: begin
        accept = out_valid_q && out_ready;
        capture = (lat_q == LAT) && (!out_valid_q || (out_ready && !out_last_q));
        lat_d = (lat_q == LAT) ? lat_q : lat_q + LW'(1);
        if (accept) begin
          out_valid_d = 1'b0;
          out_last_d = 1'b0;
          if (out_last_q) state_d = FINISH;
        end
        if (capture) begin
          out_valid_d = 1'b1;
          out_data_d = ram_rd_data;
          out_index_d = rd_addr_q;
          out_last_d = last_addr;
          if (!last_addr) begin
            rd_addr_d = rd_addr_q + MW'(1);
            lat_d = '0;
          end
        end
      end
      FINISH: begin
        list_done = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset abandons any list in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      overflow_q <= 1'b0;
      white_q <= 1'b0;
      settle_q <= 1'b0;
      move_count_q <= '0;
      rd_addr_q <= '0;
      lat_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_index_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      overflow_q <= overflow_d;
      white_q <= white_d;
      settle_q <= settle_d;
      move_count_q <= move_count_d;
      rd_addr_q <= rd_addr_d;
      lat_q <= lat_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_index_q <= out_index_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_move_list_sequencer.sv
// tb_move_list_sequencer: directed checks of the move list sequencer against a small behavioural sorter
module tb_move_list_sequencer;
  localparam int RW = 16, MPL = 3, RDL = 1;
  typedef logic [RW-1:0] arr_t [0:7];
  logic clk = 1'b0, reset = 1'b1, list_start = 1'b0, list_white_to_move = 1'b0;
  logic gen_valid = 1'b0, gen_done = 1'b0, out_ready = 1'b0;
  logic [RW-1:0] gen_data = '0;
  logic gen_ready, busy, overflow, out_valid, out_last, list_done, sort_start, sort_clear;
  logic white_to_move, ram_wr_addr_init, ram_wr, sort_complete;
  logic [MPL-1:0] move_count, out_index, ram_rd_addr, ram_wr_addr;
  logic [RW-1:0] out_data, ram_wr_data, ram_rd_data;
  int checks = 0, errors = 0, hung = 0;
  always #5 clk = ~clk;
  move_list_sequencer #(.RAM_WIDTH(RW), .MAX_POSITIONS_LOG2(MPL), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset), .list_start(list_start), .list_white_to_move(list_white_to_move),
    .gen_valid(gen_valid), .gen_data(gen_data), .gen_ready(gen_ready), .gen_done(gen_done),
    .busy(busy), .overflow(overflow), .move_count(move_count), .out_valid(out_valid),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .out_ready(out_ready),
    .list_done(list_done), .sort_start(sort_start), .sort_clear(sort_clear),
    .white_to_move(white_to_move), .ram_wr_addr_init(ram_wr_addr_init), .ram_wr(ram_wr),
    .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_addr(ram_wr_addr), .sort_complete(sort_complete));
  // Sorter stand-in: best eval (low signed byte) for the side to move comes first
  function automatic arr_t sort_list(arr_t m, int n, logic wt);
    arr_t s = m;
    logic [RW-1:0] t;
    for (int i = 0; i < n; i++)
      for (int j = 0; j + 1 < n - i; j++)
        if (wt ? ($signed(s[j][7:0]) < $signed(s[j+1][7:0])) : ($signed(s[j][7:0]) > $signed(s[j+1][7:0]))) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s;
  endfunction
  arr_t mem, srt;
  logic [MPL-1:0] wr_addr_q;
  logic prev_start;
  int sort_cnt;
  assign ram_wr_addr = wr_addr_q;
  always @(posedge clk) begin
    if (reset) begin
      wr_addr_q <= '0; sort_complete <= 1'b0; sort_cnt <= 0; prev_start <= 1'b0;
    end else begin
      prev_start <= sort_start;
      if (ram_wr_addr_init) wr_addr_q <= '0;
      else if (ram_wr) begin mem[wr_addr_q] <= ram_wr_data; wr_addr_q <= wr_addr_q + 1'b1; end
      if (sort_start && !prev_start) begin
        srt <= sort_list(mem, int'(wr_addr_q), white_to_move);
        sort_cnt <= (wr_addr_q > 1) ? 4 : 0;
        sort_complete <= (wr_addr_q <= 1);
      end else if (sort_cnt > 0) begin
        sort_cnt <= sort_cnt - 1;
        if (sort_cnt == 1) sort_complete <= 1'b1;
      end
      if (sort_clear) sort_complete <= 1'b0;
    end
    ram_rd_data <= srt[ram_rd_addr];
  end
  // Event monitor: pulse counts, accepted entries and stall stability
  int cyc = 0, n_start = 0, n_clear = 0, n_done = 0, n_valid = 0, stall_err = 0, last_cyc = 0, done_cyc = 0;
  logic [RW-1:0] acc_data[$];
  logic [MPL-1:0] acc_idx[$];
  logic acc_last[$];
  int acc_cyc[$];
  logic ss_q = 1'b0, pv = 1'b0, pr = 1'b0;
  logic [RW-1:0] pd = '0;
  logic [MPL-1:0] pidx = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ss_q <= sort_start;
    pv <= out_valid; pr <= out_ready; pd <= out_data; pidx <= out_index;
    if (!reset) begin
      if (sort_start && !ss_q) n_start <= n_start + 1;
      if (sort_clear) n_clear <= n_clear + 1;
      if (list_done) begin n_done <= n_done + 1; done_cyc <= cyc; end
      if (out_valid) n_valid <= n_valid + 1;
      if (pv && !pr && (!out_valid || out_data !== pd || out_index !== pidx)) stall_err <= stall_err + 1;
      if (out_valid && out_ready) begin
        acc_data.push_back(out_data); acc_idx.push_back(out_index); acc_last.push_back(out_last); acc_cyc.push_back(cyc);
        if (out_last) last_cyc <= cyc;
      end
    end
  end
  task automatic start_list(input logic wt);
    @(negedge clk); list_start = 1'b1; list_white_to_move = wt;
    @(negedge clk); list_start = 1'b0; list_white_to_move = 1'b0;
    for (int k = 0; k < 8 && !gen_ready; k++) @(negedge clk);
    if (!gen_ready) hung++;
  endtask
  task automatic feed(input int q[$]);
    if (q.size() == 0) begin gen_done = 1'b1; @(negedge clk); end
    for (int i = 0; i < q.size(); i++) begin
      gen_valid = 1'b1; gen_data = {8'(i + 1), 8'(q[i])}; gen_done = (i == q.size() - 1);
      @(negedge clk);
    end
    gen_valid = 1'b0; gen_done = 1'b0;
  endtask
  task automatic drain(input bit rnd);
    int d0 = n_done;
    for (int k = 0; k < 300 && n_done == d0; k++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
    end
    if (n_done == d0) hung++;
    out_ready = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, overflow, gen_ready, out_valid, out_last, list_done, sort_start, sort_clear, ram_wr, ram_wr_addr_init} !== '0)
      $display("FAIL reset_ctrl got %b want 0", {busy, overflow, gen_ready, out_valid, out_last, list_done, sort_start, sort_clear, ram_wr, ram_wr_addr_init}); else ;
    if ({busy, overflow, gen_ready, out_valid, out_last, list_done, sort_start, sort_clear, ram_wr, ram_wr_addr_init} !== '0) errors++;
    checks++; if ({move_count, ram_rd_addr} !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", {move_count, ram_rd_addr}); end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_ignored;
    gen_valid = 1'b1; gen_done = 1'b1; gen_data = 16'hABCD;
    @(negedge clk);
    checks++; if (gen_ready !== 1'b0) begin errors++; $display("FAIL idle_gen_ready got %b want 0", gen_ready); end
    @(negedge clk);
    checks++; if ({busy, ram_wr, ram_wr_addr} !== '0) begin errors++; $display("FAIL idle_ignore got %h want 0", {busy, ram_wr, ram_wr_addr}); end
    gen_valid = 1'b0; gen_done = 1'b0;
  endtask
  task automatic test_list(input logic wt, input int q[$], input logic [RW-1:0] exp[$], input bit rnd);
    int base = acc_data.size();
    start_list(wt);
    feed(q);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy got %b want 1", busy); end
    drain(rnd);
    checks++; if (move_count !== MPL'(exp.size())) begin errors++; $display("FAIL move_count got %0d want %0d", move_count, exp.size()); end
    checks++; if (acc_data.size() - base !== exp.size()) begin errors++; $display("FAIL out_count got %0d want %0d", acc_data.size() - base, exp.size()); end
    for (int k = 0; k < exp.size() && base + k < acc_data.size(); k++) begin
      checks++; if (acc_data[base+k] !== exp[k]) begin errors++; $display("FAIL out_data[%0d] got %h want %h", k, acc_data[base+k], exp[k]); end
      checks++; if (acc_idx[base+k] !== MPL'(k)) begin errors++; $display("FAIL out_index[%0d] got %0d want %0d", k, acc_idx[base+k], k); end
      checks++; if (acc_last[base+k] !== (k == exp.size() - 1)) begin errors++; $display("FAIL out_last[%0d] got %b want %b", k, acc_last[base+k], k == exp.size() - 1); end
    end
    checks++; if (done_cyc - last_cyc !== 1) begin errors++; $display("FAIL done_delay got %0d want 1", done_cyc - last_cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_end got %b want 0", busy); end
    if (!rnd && acc_data.size() >= base + 2) begin
      checks++; if (acc_cyc[base+1] - acc_cyc[base] !== RDL + 1) begin errors++; $display("FAIL throughput got %0d want %0d", acc_cyc[base+1] - acc_cyc[base], RDL + 1); end
    end
  endtask
  task automatic test_white;
    int q[$] = {3, -7, 12, 0, 5};
    logic [RW-1:0] e[$] = {16'h030C, 16'h0505, 16'h0103, 16'h0400, 16'h02F9};
    test_list(1'b1, q, e, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_white got %b want 0", overflow); end
  endtask
  task automatic test_black;
    int q[$] = {3, -7, 12, 0, 5};
    logic [RW-1:0] e[$] = {16'h02F9, 16'h0400, 16'h0103, 16'h0505, 16'h030C};
    test_list(1'b0, q, e, 1'b0);
  endtask
  task automatic test_empty;
    int q[$];
    int s0 = n_start, c0 = n_clear, d0 = n_done, v0 = n_valid;
    start_list(1'b1);
    feed(q);
    drain(1'b0);
    checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL empty_sort_start got %0d want 1", n_start - s0); end
    checks++; if (n_clear - c0 !== 1) begin errors++; $display("FAIL empty_sort_clear got %0d want 1", n_clear - c0); end
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL empty_list_done got %0d want 1", n_done - d0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL empty_out_valid got %0d want 0", n_valid - v0); end
    checks++; if (move_count !== '0) begin errors++; $display("FAIL empty_move_count got %0d want 0", move_count); end
  endtask
  task automatic test_backpressure;
    int q[$] = {20, -3, 8, 1};
    logic [RW-1:0] e[$] = {16'h0114, 16'h0308, 16'h0401, 16'h02FD};
    int st0 = stall_err;
    test_list(1'b1, q, e, 1'b1);
    checks++; if (stall_err - st0 !== 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stall_err - st0); end
  endtask
  task automatic test_overflow;
    int q[$] = {4, -2, 9, 1, -5, 7, 0, 100, 101, 102};
    logic [RW-1:0] e[$] = {16'h0309, 16'h0607, 16'h0104, 16'h0401, 16'h0700, 16'h02FE, 16'h05FB};
    test_list(1'b1, q, e, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b want 1", overflow); end
  endtask
  task automatic test_reset_mid;
    int q[$] = {1, 2};
    int q2[$] = {-1, 6};
    logic [RW-1:0] e[$] = {16'h01FF, 16'h0206};
    int d0;
    start_list(1'b1);
    feed(q);
    @(negedge clk);
    checks++; if ({busy, sort_complete} !== 2'b10) begin errors++; $display("FAIL mid_sort_wait got %b want 10", {busy, sort_complete}); end
    d0 = n_done;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy, overflow, gen_ready, out_valid, out_last, list_done, sort_start, sort_clear, ram_wr, ram_wr_addr_init, move_count, ram_rd_addr} !== '0) begin
      errors++; $display("FAIL mid_reset got %h want 0", {busy, overflow, gen_ready, out_valid, out_last, list_done, sort_start, sort_clear, ram_wr, ram_wr_addr_init, move_count, ram_rd_addr}); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (n_done !== d0) begin errors++; $display("FAIL aborted_done got %0d want %0d", n_done, d0); end
    test_list(1'b0, q2, e, 1'b0);
  endtask
  initial begin
    test_reset;
    test_ignored;
    test_white;
    test_black;
    test_empty;
    test_backpressure;
    test_overflow;
    test_reset_mid;
    checks++; if (hung !== 0) begin errors++; $display("FAIL timeout got %0d want 0", hung); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_list_sequencer.md
Name: move_list_sequencer

Overview:
Sequences one move-ordering pass through the move sort block for the search engine. It loads a generated move list into the sort RAM and starts the sort. It waits for completion, releases the sorter back to external I/O, then streams the sorted entries to the search consumer with valid/ready backpressure. One list is in flight at a time.

Parameters:
RAM_WIDTH, 0, width of one move-list entry (eval, check and capture flags, move payload); must be set by the instantiator.
MAX_POSITIONS_LOG2, $clog2(`MAX_POSITIONS), sort RAM address width.
RD_LATENCY, 1, sort RAM read latency in clocks from ram_rd_addr to ram_rd_data.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
list_start  in  1  one-cycle pulse; begin a new list; ignored unless idle
list_white_to_move  in  1  side to move, sampled on accepted list_start
gen_valid  in  1  generator entry valid
gen_data  in  RAM_WIDTH  generator entry
gen_ready  out  1  entry accepted when gen_valid && gen_ready
gen_done  in  1  one-cycle pulse; list complete; may coincide with final gen_valid
busy  out  1  high from accepted list_start until return to idle
overflow  out  1  sticky per list; entry dropped because RAM was full
move_count  out  MAX_POSITIONS_LOG2  entries loaded, valid from sort start
out_valid  out  1  sorted entry valid
out_data  out  RAM_WIDTH  sorted entry
out_index  out  MAX_POSITIONS_LOG2  rank of out_data, 0 = best
out_last  out  1  with out_valid, marks final entry
out_ready  in  1  consumer accepts when out_valid && out_ready
list_done  out  1  one-cycle pulse after last entry accepted, or after an empty list drains
sort_start  out  1  to sorter (rising-edge triggered)
sort_clear  out  1  to sorter
white_to_move  out  1  to sorter, held constant for whole list
ram_wr_addr_init  out  1  to sorter
ram_wr  out  1  to sorter
ram_wr_data  out  RAM_WIDTH  to sorter
ram_rd_addr  out  MAX_POSITIONS_LOG2  to sorter
ram_rd_data  in  RAM_WIDTH  from sorter
ram_wr_addr  in  MAX_POSITIONS_LOG2  from sorter; current fill count
sort_complete  in  1  from sorter

Behaviour:
- Reset: state IDLE. All outputs 0: busy, overflow, gen_ready, out_valid, out_last, list_done, sort_start, sort_clear, ram_wr, ram_wr_addr_init, move_count, ram_rd_addr. The sorter shares the same reset; a reset mid-list abandons the list with no list_done.
- State IDLE -> INIT: on list_start. busy<=1, overflow<=0, latch white_to_move.
- State INIT: ram_wr_addr_init=1 for one cycle -> LOAD.
- State LOAD: gen_ready=1.
  - Each handshake drives ram_wr=1 and ram_wr_data=gen_data in the same cycle (combinational pass-through). The sorter advances ram_wr_addr.
  - If ram_wr_addr == 2**MAX_POSITIONS_LOG2-1, the entry is accepted but not written, and overflow<=1. Capacity is 2**MAX_POSITIONS_LOG2-1 entries.
  - gen_done -> START. A coinciding final entry is still written.
- State START: move_count<=ram_wr_addr; sort_start=1 for exactly one cycle -> SORT_WAIT. sort_start is low in every other state, so each list gives exactly one rising edge.
- State SORT_WAIT: wait for sort_complete=1, then sort_clear=1 for one cycle -> SETTLE.
  - Count 0 or 1 still goes through the sort; the sorter completes immediately.
- State SETTLE: 2 cycles while the sorter returns to external I/O; ram_rd_addr<=0 -> DRAIN or FINISH.
  - If move_count==0 -> FINISH.
- State DRAIN: per entry, hold ram_rd_addr and wait RD_LATENCY cycles. Then capture into the output register: out_valid=1, out_index=ram_rd_addr, out_last=(ram_rd_addr==move_count-1).
  - Hold out_* stable until out_ready.
  - On acceptance: out_valid<=0. If last -> FINISH, else ram_rd_addr+1 and repeat.
  - Throughput: one entry per RD_LATENCY+1 cycles with out_ready tied high.
- State FINISH: list_done=1 for one cycle; busy<=0 -> IDLE.
- Ignored inputs: gen_valid outside LOAD is ignored with gen_ready=0. list_start while busy is ignored. gen_done outside LOAD is ignored.
- Ordering is the sorter's: best-for-side-to-move first.
- Widths: all counters MAX_POSITIONS_LOG2 bits unsigned. No wrap, because overflow stops writes.

Test Plan:
- Load 5 entries with evals {3,-7,12,0,5}, white to move, out_ready=1. Required: out_index 0..4 carries evals 12,5,3,0,-7; out_last only on index 4; list_done one cycle later; move_count=5.
- Same list with black to move. Required: output evals -7,0,3,5,12.
- gen_done with no entries. Required: exactly one sort_start pulse and one sort_clear pulse; no out_valid; list_done pulse; move_count=0.
- Toggle out_ready randomly on a 4-entry list. Required: out_data/out_index stable while stalled; each entry delivered exactly once and in order.
- Offer 2**MAX_POSITIONS_LOG2+2 entries. Required: overflow=1; move_count=2**MAX_POSITIONS_LOG2-1; output sorted and complete for the stored entries.
- Assert reset during SORT_WAIT, then start a new 2-entry list. Required: all outputs return to 0; no list_done for the aborted list; the new list sorts and drains correctly.
